// File: rtl/demux_pkg.sv
// Shared constants and types for the registered stream demultiplexer.
package demux_pkg;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_NCH    = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int ERR_W      = 8;

  // Holds an occupancy of 0..FIFO_DEPTH.
  typedef logic [1:0] cnt_t;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry in-order FIFO; ent0 is always the head word.
module demux_fifo2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output cnt_t             count,
  output logic             full
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == cnt_t'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = ent0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == '0) ent0 <= din;
          else             ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        // Push into a full FIFO is blocked, so count is 1 here.
        2'b11: ent0 <= din;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/demux_stream.sv
// 1-to-NCH stream demux with unicast/broadcast steering, per-channel 2-deep
// buffering and a saturating count of words dropped for an illegal select.
module demux_stream
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NCH   = DEF_NCH,
  localparam int SEL_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_bcast,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [ERR_W-1:0]     err_count
);

  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] full;
  cnt_t           cnt [NCH];
  logic           sel_legal;
  logic           accept;
  logic [ERR_W-1:0] err_q;

  assign sel_legal = (int'(in_sel) < NCH);

  // Ready looks only at registered occupancy and the current steering inputs.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast)       in_ready = ~|full;
    else if (sel_legal) in_ready = !full[in_sel];
  end

  assign accept = in_valid && in_ready && !rst;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign push[k]      = accept && (in_bcast || (sel_legal && (int'(in_sel) == k)));
    assign pop[k]       = out_valid[k] && out_ready[k];
    assign out_valid[k] = (cnt[k] != '0);

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (in_data),
      .head  (out_data[k*WIDTH +: WIDTH]),
      .count (cnt[k]),
      .full  (full[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (accept && !in_bcast && !sel_legal && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_count = err_q;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: a 4-channel instance tracked by a queue model and a
// 3-channel instance used for the illegal-select counter.
module tb_demux_stream;

  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          v4, bc4, rdy4;
  logic [W-1:0]  d4;
  logic [1:0]    sel4;
  logic [3:0]    ordy4, ovld4;
  logic [4*W-1:0] odat4;
  logic [7:0]    err4;

  logic          v3, bc3, rdy3;
  logic [W-1:0]  d3;
  logic [1:0]    sel3;
  logic [2:0]    ordy3, ovld3;
  logic [3*W-1:0] odat3;
  logic [7:0]    err3;

  demux_stream #(.WIDTH(W), .NCH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .in_sel(sel4), .in_bcast(bc4), .out_valid(ovld4), .out_ready(ordy4),
    .out_data(odat4), .err_count(err4)
  );

  demux_stream #(.WIDTH(W), .NCH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_data(d3),
    .in_sel(sel3), .in_bcast(bc3), .out_valid(ovld3), .out_ready(ordy3),
    .out_data(odat3), .err_count(err3)
  );

  // Reference model of the 4-channel instance: one queue per consumer.
  logic [W-1:0] q [4][$];
  int checks = 0;
  int passes = 0;

  function automatic bit m_ready();
    if (bc4) begin
      for (int k = 0; k < 4; k++) if (q[k].size() >= 2) return 1'b0;
      return 1'b1;
    end
    return q[sel4].size() < 2;
  endfunction

  function automatic logic [3:0] m_valid();
    logic [3:0] r = '0;
    for (int k = 0; k < 4; k++) r[k] = (q[k].size() != 0);
    return r;
  endfunction

  function automatic logic [4*W-1:0] m_data();
    logic [4*W-1:0] r = '0;
    for (int k = 0; k < 4; k++) if (q[k].size() != 0) r[k*W +: W] = q[k][0];
    return r;
  endfunction

  function automatic logic [4*W-1:0] m_mask();
    logic [4*W-1:0] r = '0;
    for (int k = 0; k < 4; k++) if (q[k].size() != 0) r[k*W +: W] = '1;
    return r;
  endfunction

  // Advance one clock, moving the model the same way the spec moves the DUT.
  task automatic tick();
    bit acc;
    acc = v4 && m_ready() && !rst;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++)
        if (q[k].size() != 0 && ordy4[k]) void'(q[k].pop_front());
      if (acc)
        for (int k = 0; k < 4; k++)
          if (bc4 || int'(sel4) == k) q[k].push_back(d4);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bc4 = 1'b1;
    #1;
    checks++; if (ovld4 !== 4'b0) $display("FAIL reset_valid got %b want 0000", ovld4); else passes++;
    checks++; if (odat4 !== '0) $display("FAIL reset_data got %h want 000", odat4); else passes++;
    checks++; if (err4 !== 8'd0) $display("FAIL reset_err4 got %0d want 0", err4); else passes++;
    checks++; if (err3 !== 8'd0) $display("FAIL reset_err3 got %0d want 0", err3); else passes++;
    checks++; if (rdy4 !== 1'b1) $display("FAIL reset_ready_bcast got %b want 1", rdy4); else passes++;
    bc4 = 1'b0;
    sel4 = 2'd2;
    #1;
    checks++; if (rdy4 !== 1'b1) $display("FAIL reset_ready_uni got %b want 1", rdy4); else passes++;
  endtask

  task automatic test_unicast();
    ordy4 = 4'hF;
    for (int k = 0; k < 4; k++) begin
      v4 = 1'b1; d4 = 3'b111; sel4 = 2'(k); bc4 = 1'b0;
      #1;
      checks++; if (rdy4 !== 1'b1) $display("FAIL uni_ready ch%0d got %b want 1", k, rdy4); else passes++;
      tick();
      checks++; if (ovld4 !== (4'b1 << k)) $display("FAIL uni_valid ch%0d got %b want %b", k, ovld4, 4'b1 << k); else passes++;
      checks++; if (odat4[k*W +: W] !== 3'b111) $display("FAIL uni_data ch%0d got %b want 111", k, odat4[k*W +: W]); else passes++;
    end
    v4 = 1'b0;
    tick();
    checks++; if (ovld4 !== 4'b0) $display("FAIL uni_drain got %b want 0000", ovld4); else passes++;
  endtask

  task automatic test_backpressure();
    ordy4 = 4'b1011; v4 = 1'b1; sel4 = 2'd2; bc4 = 1'b0;
    d4 = 3'b001; #1;
    checks++; if (rdy4 !== 1'b1) $display("FAIL bp_ready1 got %b want 1", rdy4); else passes++;
    tick();
    d4 = 3'b010; #1;
    checks++; if (rdy4 !== 1'b1) $display("FAIL bp_ready2 got %b want 1", rdy4); else passes++;
    tick();
    d4 = 3'b011; #1;
    checks++; if (rdy4 !== 1'b0) $display("FAIL bp_ready_full got %b want 0", rdy4); else passes++;
    tick();
    checks++; if (odat4[2*W +: W] !== 3'b001) $display("FAIL bp_head1 got %b want 001", odat4[2*W +: W]); else passes++;
    ordy4 = 4'hF; #1;
    checks++; if (rdy4 !== 1'b0) $display("FAIL bp_ready_no_comb got %b want 0", rdy4); else passes++;
    tick();
    checks++; if (ovld4[2] !== 1'b1 || odat4[2*W +: W] !== 3'b010) $display("FAIL bp_head2 got %b/%b want 1/010", ovld4[2], odat4[2*W +: W]); else passes++;
    #1;
    checks++; if (rdy4 !== 1'b1) $display("FAIL bp_ready_reopen got %b want 1", rdy4); else passes++;
    tick();
    checks++; if (ovld4 !== 4'b0100 || odat4[2*W +: W] !== 3'b011) $display("FAIL bp_head3 got %b/%b want 0100/011", ovld4, odat4[2*W +: W]); else passes++;
    v4 = 1'b0;
    tick();
  endtask

  task automatic test_bcast();
    ordy4 = 4'hF; v4 = 1'b1; bc4 = 1'b1; d4 = 3'b101;
    #1;
    checks++; if (rdy4 !== 1'b1) $display("FAIL bc_ready got %b want 1", rdy4); else passes++;
    tick();
    checks++; if (ovld4 !== 4'hF) $display("FAIL bc_valid got %b want 1111", ovld4); else passes++;
    checks++; if (odat4 !== {4{3'b101}}) $display("FAIL bc_data got %h want %h", odat4, {4{3'b101}}); else passes++;
    ordy4 = 4'b1101; bc4 = 1'b0; sel4 = 2'd1; d4 = 3'b110;
    tick();
    bc4 = 1'b1; d4 = 3'b010;
    #1;
    checks++; if (rdy4 !== 1'b0) $display("FAIL bc_blocked_ready got %b want 0", rdy4); else passes++;
    tick();
    checks++; if (ovld4 !== 4'b0010) $display("FAIL bc_blocked_valid got %b want 0010", ovld4); else passes++;
    checks++; if (odat4[W +: W] !== 3'b101) $display("FAIL bc_blocked_head got %b want 101", odat4[W +: W]); else passes++;
    v4 = 1'b0; bc4 = 1'b0; ordy4 = 4'hF;
    tick();
    tick();
  endtask

  task automatic test_same_cycle();
    ordy4 = 4'b0000; v4 = 1'b1; sel4 = 2'd0; bc4 = 1'b0; d4 = 3'b011;
    tick();
    ordy4 = 4'b0001; d4 = 3'b110;
    #1;
    checks++; if (rdy4 !== 1'b1) $display("FAIL sc_ready got %b want 1", rdy4); else passes++;
    tick();
    checks++; if (ovld4 !== 4'b0001 || odat4[0 +: W] !== 3'b110) $display("FAIL sc_head got %b/%b want 0001/110", ovld4, odat4[0 +: W]); else passes++;
    v4 = 1'b0;
    tick();
    checks++; if (ovld4 !== 4'b0000) $display("FAIL sc_count_one got %b want 0000", ovld4); else passes++;
    ordy4 = 4'hF;
  endtask

  task automatic test_illegal();
    int exp_err;
    exp_err = 0;
    v3 = 1'b1; sel3 = 2'd3; bc3 = 1'b0; ordy3 = 3'b111;
    for (int i = 0; i < 3; i++) begin
      d3 = W'($urandom);
      #1;
      checks++; if (rdy3 !== 1'b1) $display("FAIL ill_ready%0d got %b want 1", i, rdy3); else passes++;
      tick();
      exp_err++;
      checks++; if (ovld3 !== 3'b000) $display("FAIL ill_valid%0d got %b want 000", i, ovld3); else passes++;
    end
    checks++; if (err3 !== 8'(exp_err)) $display("FAIL ill_err3 got %0d want %0d", err3, exp_err); else passes++;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_err < 255) exp_err++;
    end
    checks++; if (err3 !== 8'(exp_err)) $display("FAIL ill_saturate got %0d want %0d", err3, exp_err); else passes++;
    bc3 = 1'b1; d3 = 3'b100;
    tick();
    checks++; if (err3 !== 8'd255 || ovld3 !== 3'b111) $display("FAIL ill_bcast got %0d/%b want 255/111", err3, ovld3); else passes++;
    v3 = 1'b0; bc3 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int bad_rdy, bad_vld, bad_dat;
    bad_rdy = 0; bad_vld = 0; bad_dat = 0;
    for (int i = 0; i < 400; i++) begin
      v4 = 1'($urandom);
      d4 = W'($urandom);
      sel4 = 2'($urandom);
      bc4 = ($urandom_range(0, 7) == 0);
      ordy4 = 4'($urandom);
      #1;
      checks++; if (rdy4 !== m_ready()) begin bad_rdy++; $display("FAIL rnd_ready cyc%0d got %b want %b", i, rdy4, m_ready()); end else passes++;
      tick();
      checks++; if (ovld4 !== m_valid()) begin bad_vld++; $display("FAIL rnd_valid cyc%0d got %b want %b", i, ovld4, m_valid()); end else passes++;
      checks++; if ((odat4 & m_mask()) !== m_data()) begin bad_dat++; $display("FAIL rnd_data cyc%0d got %h want %h", i, odat4 & m_mask(), m_data()); end else passes++;
      if (bad_rdy + bad_vld + bad_dat > 10) break;
    end
    checks++; if (err4 !== 8'd0) $display("FAIL rnd_err4 got %0d want 0", err4); else passes++;
    v4 = 1'b0; ordy4 = 4'hF;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    ordy4 = 4'b0000; v4 = 1'b1; bc4 = 1'b0;
    sel4 = 2'd0; d4 = 3'b001;
    tick();
    sel4 = 2'd3; d4 = 3'b010;
    tick();
    checks++; if (ovld4 !== 4'b1001) $display("FAIL rm_filled got %b want 1001", ovld4); else passes++;
    rst = 1'b1; sel4 = 2'd1; d4 = 3'b111;
    tick();
    rst = 1'b0; v4 = 1'b0;
    #1;
    checks++; if (ovld4 !== 4'b0000) $display("FAIL rm_valid got %b want 0000", ovld4); else passes++;
    checks++; if (odat4 !== '0) $display("FAIL rm_data got %h want 000", odat4); else passes++;
    checks++; if (err4 !== 8'd0 || err3 !== 8'd0) $display("FAIL rm_err got %0d/%0d want 0/0", err4, err3); else passes++;
    tick();
    checks++; if (ovld4 !== 4'b0000) $display("FAIL rm_no_accept got %b want 0000", ovld4); else passes++;
  endtask

  initial begin
    v4 = 1'b0; bc4 = 1'b0; d4 = '0; sel4 = '0; ordy4 = '0;
    v3 = 1'b0; bc3 = 1'b0; d3 = '0; sel3 = '0; ordy3 = '0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_bcast();
    test_same_cycle();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
# demux_stream

Parametrised, registered 1-to-NCH stream demultiplexer with valid/ready handshaking. It is the successor to the combinational 1-to-4 demux. Each accepted input word is steered by a select field to one output channel, or broadcast to all channels, and held in a 2-entry per-channel buffer so downstream back-pressure never corrupts data. It sits between a single producer and NCH independent consumers and counts words dropped because of an illegal select.

## Interface
- WIDTH, default 3: data width in bits.
- NCH, default 4: number of output channels, 2..16.
- SEL_W, default $clog2(NCH): select width; derived, not overridden.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  input word.
- in_sel  in  SEL_W  destination channel.
- in_bcast  in  1  1 means deliver to every channel; in_sel is ignored.
- out_valid  out  NCH  bit k: channel k head word valid.
- out_ready  in  NCH  bit k: consumer k takes the head word.
- out_data  out  NCH*WIDTH  channel k head word in slice [k*WIDTH +: WIDTH].
- err_count  out  8  number of words dropped for in_sel >= NCH; saturates at 255.

## Operation
- Accept condition: in_valid && in_ready.
- Unicast, in_sel < NCH: in_ready = (fifo[in_sel] count < 2). On accept, in_data is pushed into fifo[in_sel] only.
- Unicast, in_sel >= NCH (possible only when NCH is not a power of 2): in_ready = 1. On accept the word is discarded, no FIFO changes, and err_count increments unless it is already 255.
- Broadcast: in_ready = every FIFO count < 2. On accept, in_data is pushed into all NCH FIFOs in the same cycle. Broadcast never increments err_count.
- in_ready depends only on registered FIFO counts and the current in_sel/in_bcast. It never depends on out_ready, so there is no combinational path from out_ready to in_ready.
- Per-channel FIFO: depth 2, in-order. out_valid[k] = (count_k != 0). out_data slice k is the head entry. A pop occurs when out_valid[k] && out_ready[k].
- Push and pop on the same FIFO in the same cycle:
  - count 1: count stays 1, the new word becomes the head next cycle.
  - count 2: this case cannot occur, because push is blocked.
- The FIFO is never written when full and never read when empty. out_ready[k] while out_valid[k]=0 is ignored.
- Channels are independent. A stalled channel blocks only unicasts to that channel and all broadcasts.

## Timing
- Latency: a word accepted in cycle t is visible on out_valid/out_data in cycle t+1.
- Throughput: 1 word/cycle per channel when its consumer holds out_ready=1.
- A channel reaches full 2 cycles after its consumer stalls, under continuous pushes.
- Reset values, all forced in the cycle rst is sampled high:
  - all FIFO counts 0, so out_valid = 0
  - out_data = 0 (storage cleared)
  - err_count = 0
  - in_ready reflects the empty FIFOs: 1 for any in_sel/in_bcast.
- Reset mid-operation discards all buffered words. No handshake completes in a reset cycle; a word presented with rst=1 is not accepted.
- err_count wraps never; it holds at 255.

## Structure
- Package demux_pkg holds:
  - default WIDTH and NCH constants
  - FIFO_DEPTH = 2
  - ERR_W = 8
  - a count type sized for 0..2.
- Sub-module demux_fifo2 is a 2-entry synchronous FIFO with push/pop/count/head/full. It is instantiated NCH times via generate.
- The top level holds the select decode, in_ready logic, broadcast fan-out and err_count.

## Test plan
- Reset, then D=3'b111 unicast with sel=0,1,2,3 on consecutive cycles, all out_ready=1 -> out_valid one-hot 0001,0010,0100,1000 each one cycle after accept, with data 111 on the matching slice.
- out_ready[2]=0, push 3'b001, 3'b010, 3'b011 to sel=2 -> first two accepted, in_ready=0 on the third. Raise out_ready[2] -> pops 001 then 010, then 011 is accepted.
- Broadcast 3'b101 with all channels empty -> next cycle out_valid=1111 and all slices 101. Repeat with channel 1 full -> in_ready=0 and no channel is written.
- NCH=3: send sel=3 three times -> in_ready=1, err_count=3, out_valid stays 000. Force 300 illegal words -> err_count=255.
- Channel 0 holding 1 word, simultaneous push of 3'b110 and pop -> count stays 1 and the head becomes 110 next cycle.
- Fill channels 0 and 3, assert rst for one cycle -> out_valid=0000, out_data=0, err_count=0. A word presented during rst is not accepted.
